// File: rtl/triangle_uploader.sv
// triangle_uploader: sends a 3-byte triangle count and then 18 bytes per triangle word to a UART transmitter, every field LSB first.
// Optional feature: define UPLOAD_CHECKSUM_EN to append one byte holding the XOR of all bytes sent.
module triangle_uploader (
    input  logic         clk,
    input  logic         system_rst_n,
    input  logic         start,
    input  logic [23:0]  num_triangles,
    output logic [31:0]  tri_addr,
    output logic         tri_rd,
    input  logic [143:0] tri_rdata,
    output logic [7:0]   tx_data,
    output logic         trmt,
    input  logic         tx_done,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_CNT = 3'd1,
        FETCH    = 3'd2,
        WAIT_RD  = 3'd3,
        SEND_TRI = 3'd4,
`ifdef UPLOAD_CHECKSUM_EN
        CHKSUM   = 3'd5,
`endif
        FINISH   = 3'd6
    } state_t;

    state_t         state_q;
    logic [23:0]    cnt_q;
    logic [23:0]    idx_q;
    logic [4:0]     byte_cnt_q;
    logic [143:0]   shift_q;
    logic [7:0]     tx_data_q;
    logic [31:0]    tri_addr_q;
    logic           trmt_q;
    logic           tri_rd_q;
    logic           busy_q;
    logic           done_q;
`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]     chk_q;
`endif
    logic [23:0]    idx_inc;

    assign idx_inc  = idx_q + 24'd1;

    assign tri_addr = tri_addr_q;
    assign tri_rd   = tri_rd_q;
    assign tx_data  = tx_data_q;
    assign trmt     = trmt_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // NOTE: every register, the 144-bit shift register included, is a plain flop and is
    // cleared by the async reset; all state uses non-blocking assignments so the
    // default-then-override pattern below resolves to the last assignment.
    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tri_addr_q <= '0;
            trmt_q     <= 1'b0;
            tri_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            trmt_q   <= 1'b0;
            tri_rd_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
            if (tx_done && (state_q == SEND_CNT || state_q == SEND_TRI))
                chk_q <= chk_q ^ tx_data_q;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SEND_CNT;
                        busy_q     <= 1'b1;
                        cnt_q      <= num_triangles;
                        idx_q      <= '0;
                        byte_cnt_q <= '0;
                        trmt_q     <= 1'b1;
                        tx_data_q  <= num_triangles[7:0];
`ifdef UPLOAD_CHECKSUM_EN
                        chk_q      <= '0;
`endif
                    end
                end

                SEND_CNT: begin
                    if (tx_done) begin
                        if (byte_cnt_q == 5'd2) begin
                            byte_cnt_q <= '0;
                            if (cnt_q == 24'd0) begin
`ifdef UPLOAD_CHECKSUM_EN
                                state_q   <= CHKSUM;
                                trmt_q    <= 1'b1;
                                tx_data_q <= chk_q ^ tx_data_q;
`else
                                state_q   <= FINISH;
                                done_q    <= 1'b1;
`endif
                            end else begin
                                state_q    <= FETCH;
                                tri_rd_q   <= 1'b1;
                                tri_addr_q <= {8'd0, idx_q};
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 5'd1;
                            trmt_q     <= 1'b1;
                            tx_data_q  <= (byte_cnt_q == 5'd0) ? cnt_q[15:8] : cnt_q[23:16];
                        end
                    end
                end

                // tri_rd is raised on entry so the read strobe coincides with the FETCH cycle.
                FETCH: begin
                    state_q <= WAIT_RD;
                end

                WAIT_RD: begin
                    state_q   <= SEND_TRI;
                    shift_q   <= tri_rdata;
                    tx_data_q <= tri_rdata[7:0];
                    trmt_q    <= 1'b1;
                end

                SEND_TRI: begin
                    if (tx_done) begin
                        shift_q <= shift_q >> 8;
                        if (byte_cnt_q == 5'd17) begin
                            byte_cnt_q <= '0;
                            idx_q      <= idx_inc;
                            if (idx_inc == cnt_q) begin
`ifdef UPLOAD_CHECKSUM_EN
                                state_q   <= CHKSUM;
                                trmt_q    <= 1'b1;
                                tx_data_q <= chk_q ^ tx_data_q;
`else
                                state_q   <= FINISH;
                                done_q    <= 1'b1;
`endif
                            end else begin
                                state_q    <= FETCH;
                                tri_rd_q   <= 1'b1;
                                tri_addr_q <= {8'd0, idx_inc};
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 5'd1;
                            trmt_q     <= 1'b1;
                            tx_data_q  <= shift_q[15:8];
                        end
                    end
                end

`ifdef UPLOAD_CHECKSUM_EN
                CHKSUM: begin
                    if (tx_done) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end
                end
`endif

                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_uploader.sv
// Self-checking bench for triangle_uploader: a byte-stream model built from the count and memory contents,
// with UART and memory responders; honours UPLOAD_CHECKSUM_EN when defined.
module tb_triangle_uploader;

    logic         clk;
    logic         system_rst_n;
    logic         start;
    logic [23:0]  num_triangles;
    logic [31:0]  tri_addr;
    logic         tri_rd;
    logic [143:0] tri_rdata;
    logic [7:0]   tx_data;
    logic         trmt;
    logic         tx_done;
    logic         busy;
    logic         done;

    logic         uart_done;
    logic         spur_done;
    assign tx_done = uart_done | spur_done;

    triangle_uploader dut (
        .clk           (clk),
        .system_rst_n  (system_rst_n),
        .start         (start),
        .num_triangles (num_triangles),
        .tri_addr      (tri_addr),
        .tri_rd        (tri_rd),
        .tri_rdata     (tri_rdata),
        .tx_data       (tx_data),
        .trmt          (trmt),
        .tx_done       (tx_done),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [143:0] rand144();
        logic [143:0] v;
        v = '0;
        for (int i = 0; i < 18; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    // Shared test knobs and model state.
    logic [143:0] mem [0:15];
    int           dly_min = 1;
    int           dly_max = 1;
    bit           spur_en = 1'b0;
    int           reset_epoch = 0;

    logic [7:0]   exp_q[$];
    int           addr_q[$];
    logic [7:0]   got[$];
    int           addr_got[$];
    int           trmt_cnt = 0;
    int           ack_cnt  = 0;
    int           rd_cnt   = 0;
    int           done_cnt = 0;

    always @(negedge system_rst_n) reset_epoch++;

    // Reference stream: count LSB first, then each triangle word LSB first, optional XOR byte.
    function automatic void build_expected(input logic [23:0] n);
        logic [7:0] x;
        exp_q.delete();
        addr_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(n[8*k +: 8]);
        for (int t = 0; t < int'(n); t++) begin
            addr_q.push_back(t);
            for (int b = 0; b < 18; b++) exp_q.push_back(mem[t[3:0]][8*b +: 8]);
        end
`ifdef UPLOAD_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
        if (x != 8'h00) exp_q.push_back(x);
`endif
    endfunction

    // UART responder: acknowledges each trmt after a random delay, abandoned on reset.
    int uart_d;
    int uart_ep;
    initial begin
        uart_done = 1'b0;
        forever begin
            @(negedge clk);
            if (system_rst_n && trmt) begin
                uart_d  = $urandom_range(dly_max, dly_min);
                uart_ep = reset_epoch;
                repeat (uart_d) @(posedge clk);
                #1;
                if (uart_ep == reset_epoch && system_rst_n) begin
                    uart_done = 1'b1;
                    @(posedge clk);
                    #1;
                    uart_done = 1'b0;
                end
            end
        end
    end

    // Memory responder: data valid only in the cycle after the read strobe; optional stray tx_done then.
    logic [31:0] mem_a;
    initial begin
        tri_rdata = '0;
        spur_done = 1'b0;
        forever begin
            @(negedge clk);
            if (system_rst_n && tri_rd) begin
                mem_a = tri_addr;
                @(posedge clk);
                #1;
                tri_rdata = mem[mem_a[3:0]];
                spur_done = spur_en;
                @(posedge clk);
                #1;
                tri_rdata = rand144();
                spur_done = 1'b0;
            end
        end
    end

    // Compare process: checks every output every cycle against the model.
    bit         exp_busy = 1'b0;
    bit         prev_accept = 1'b0;
    bit         prev_done = 1'b0;
    bit         expect_done = 1'b0;
    bit         outstanding = 1'b0;
    bit         waiting_gap = 1'b0;
    int         gap = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_b;
    int         exp_a;

    always @(negedge clk) begin
        if (!system_rst_n) begin
            exp_q.delete();
            addr_q.delete();
            exp_busy    = 1'b0;
            prev_accept = 1'b0;
            prev_done   = 1'b0;
            expect_done = 1'b0;
            outstanding = 1'b0;
            waiting_gap = 1'b0;
        end else begin
            if (prev_accept) exp_busy = 1'b1;
            if (prev_done)   exp_busy = 1'b0;
            check("busy", busy, exp_busy);
            check("done", done, expect_done);
            expect_done = 1'b0;
            if (done) begin
                done_cnt++;
                check("bytes_left_at_done", exp_q.size(), 0);
                check("reads_left_at_done", addr_q.size(), 0);
            end
            if (tri_rd) begin
                rd_cnt++;
                addr_got.push_back(int'(tri_addr));
                check("rd_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) begin
                    exp_a = addr_q.pop_front();
                    check("tri_addr", tri_addr, exp_a);
                end
            end
            if (waiting_gap) gap++;
            if (trmt) begin
                trmt_cnt++;
                got.push_back(tx_data);
                check("trmt_overlap", outstanding, 0);
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("tx_data", tx_data, exp_b);
                end
                if (waiting_gap) check("tx_gap_le3", gap <= 3, 1);
                waiting_gap = 1'b0;
                held        = tx_data;
                outstanding = 1'b1;
            end else begin
                if (outstanding) check("tx_data_stable", tx_data, held);
                if (waiting_gap && gap > 3) begin
                    check("tx_gap", gap, 3);
                    waiting_gap = 1'b0;
                end
            end
            if (tx_done && outstanding && !trmt) begin
                outstanding = 1'b0;
                ack_cnt++;
                if (exp_q.size() == 0) expect_done = 1'b1;
                else begin
                    waiting_gap = 1'b1;
                    gap         = 0;
                end
            end
            prev_accept = start && !exp_busy;
            if (prev_accept) build_expected(num_triangles);
            prev_done = done;
        end
    end

    task automatic pulse_start(input logic [23:0] n);
        @(posedge clk);
        #1;
        start         = 1'b1;
        num_triangles = n;
        @(posedge clk);
        #1;
        start         = 1'b0;
        num_triangles = 24'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_within_budget", n < budget, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_trmt"}, trmt, 0);
        check({tag, "_tri_rd"}, tri_rd, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tri_addr"}, tri_addr, 0);
    endtask

    int chk_extra;
    int base_trmt;
    int base_ack;
    int base_rd;
    int n_rand;
    int wait_n;

    initial begin
`ifdef UPLOAD_CHECKSUM_EN
        chk_extra = 1;
`else
        chk_extra = 0;
`endif
        system_rst_n  = 1'b1;
        start         = 1'b0;
        num_triangles = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #3 system_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        system_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Zero triangles: only the count bytes, no memory reads.
        got.delete();
        base_rd = rd_cnt;
        pulse_start(24'd0);
        wait_done(200);
        check("n0_len", got.size(), 3 + chk_extra);
        check("n0_b0", got[0], 8'h00);
        check("n0_b2", got[2], 8'h00);
        check("n0_no_rd", rd_cnt - base_rd, 0);

        // Two triangles with known contents.
        mem[0] = 144'h0102030405060708090A0B0C0D0E0F101112;
        mem[1] = {18{8'hAA}};
        got.delete();
        addr_got.delete();
        pulse_start(24'd2);
        wait_done(500);
        check("n2_len", got.size(), 39 + chk_extra);
        check("n2_cnt0", got[0], 8'h02);
        check("n2_cnt1", got[1], 8'h00);
        check("n2_t0_first", got[3], 8'h12);
        check("n2_t0_last", got[20], 8'h01);
        check("n2_t1_first", got[21], 8'hAA);
        check("n2_t1_last", got[38], 8'hAA);
        check("n2_addr0", addr_got[0], 0);
        check("n2_addr1", addr_got[1], 1);
`ifdef UPLOAD_CHECKSUM_EN
        check("n2_chksum", got[39], 8'h02 ^ 8'h13);
`endif

        // Slow transmitter plus a stray tx_done during each memory wait.
        mem[0]    = rand144();
        mem[1]    = rand144();
        dly_min   = 100;
        dly_max   = 100;
        spur_en   = 1'b1;
        got.delete();
        base_trmt = trmt_cnt;
        base_ack  = ack_cnt;
        pulse_start(24'd2);
        wait_done(6000);
        check("slow_trmt_count", trmt_cnt - base_trmt, 39 + chk_extra);
        check("slow_ack_count", ack_cnt - base_ack, 39 + chk_extra);
        spur_en = 1'b0;
        dly_min = 1;
        dly_max = 3;

        // A second start while busy must be ignored.
        got.delete();
        pulse_start(24'd2);
        repeat (20) @(posedge clk);
        #1;
        start         = 1'b1;
        num_triangles = 24'd5;
        @(posedge clk);
        #1;
        start         = 1'b0;
        wait_done(500);
        check("restart_ignored_len", got.size(), 39 + chk_extra);
        check("restart_ignored_cnt0", got[0], 8'h02);

        // Reset in the middle of the first triangle, then a clean upload.
        mem[0] = 144'h0102030405060708090A0B0C0D0E0F101112;
        mem[1] = {18{8'hAA}};
        dly_min = 2;
        dly_max = 2;
        base_trmt = trmt_cnt;
        pulse_start(24'd2);
        wait_n = 0;
        while (trmt_cnt - base_trmt < 13 && wait_n < 300) begin
            @(posedge clk);
            wait_n++;
        end
        check("reached_10th_byte", wait_n < 300, 1);
        @(posedge clk);
        #1;
        system_rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        system_rst_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        pulse_start(24'd2);
        wait_done(500);
        check("post_reset_len", got.size(), 39 + chk_extra);
        check("post_reset_cnt0", got[0], 8'h02);
        check("post_reset_t0_first", got[3], 8'h12);

        // Randomised uploads.
        for (int r = 0; r < 4; r++) begin
            n_rand  = $urandom_range(5, 1);
            dly_min = 1;
            dly_max = $urandom_range(4, 1);
            spur_en = 1'($urandom);
            for (int t = 0; t < n_rand; t++) mem[t] = rand144();
            got.delete();
            pulse_start(24'(n_rand));
            wait_done(1500);
            check("rand_len", got.size(), 3 + 18 * n_rand + chk_extra);
        end
        spur_en = 1'b0;

`ifdef UPLOAD_CHECKSUM_EN
        // One all-zero triangle: checksum equals the count byte.
        mem[0] = '0;
        got.delete();
        pulse_start(24'd1);
        wait_done(500);
        check("chk_len", got.size(), 22);
        check("chk_cnt0", got[0], 8'h01);
        check("chk_byte", got[21], 8'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/triangle_uploader.md
TRIANGLE_UPLOADER -- requirements
Module: triangle_uploader

Interface
REQ-001 clk  input  1  system clock; all state changes on the rising edge.
REQ-002 system_rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  single-cycle request to begin an upload; sampled only in IDLE.
REQ-004 num_triangles  input  24  number of triangles to send; captured on accepted start.
REQ-005 tri_addr  output  32  triangle memory read address.
REQ-006 tri_rd  output  1  one-cycle read strobe; tri_rdata is valid exactly 1 cycle later.
REQ-007 tri_rdata  input  144  triangle word from triangle memory.
REQ-008 tx_data  output  8  byte presented to the UART transmitter; stable from trmt until tx_done.
REQ-009 trmt  output  1  one-cycle pulse that starts transmission of tx_data.
REQ-010 tx_done  input  1  one-cycle pulse from the UART transmitter when the current byte has finished.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the last byte's tx_done.

Function
REQ-013 The stream format shall be the bootload format: a 3-byte count, then 18 bytes per triangle, with every field sent least-significant byte first.
REQ-014 Count bytes shall be sent in the order cnt[7:0], cnt[15:8], cnt[23:16]; triangle bytes shall be sent in the order [7:0], [15:8], … [143:136].
REQ-015 The block shall implement these states: IDLE, SEND_CNT, FETCH, WAIT_RD, SEND_TRI, CHKSUM, FINISH.
REQ-016 IDLE -> SEND_CNT on start; num_triangles is latched, the triangle index is cleared, and the byte counter is cleared in the same cycle.
REQ-017 Byte handshake in every SEND state: pulse trmt for one cycle with tx_data valid, then hold until tx_done; at tx_done, advance the byte counter and pulse trmt for the next byte in the following cycle.
REQ-018 tx_done shall be ignored in IDLE, FETCH and WAIT_RD.
REQ-019 After the 3rd count byte's tx_done: if the latched count is 0, go to CHKSUM or FINISH (see REQ-029/030); otherwise go to FETCH.
REQ-020 FETCH: drive tri_addr = triangle index, zero-extended to 32 bits, and pulse tri_rd for one cycle; go to WAIT_RD.
REQ-021 WAIT_RD: capture tri_rdata into a 144-bit shift register and go to SEND_TRI.
REQ-022 SEND_TRI: tx_data = shift[7:0]; on each tx_done, shift right by 8; after the 18th tx_done, increment the index.
REQ-023 After the 18th tx_done: if index+1 == latched count, go to CHKSUM or FINISH; otherwise go to FETCH.
REQ-024 Worst-case gap between a tx_done and the next trmt shall be 3 cycles (across FETCH/WAIT_RD); within a field the gap shall be 1 cycle.
REQ-025 FINISH: pulse done for one cycle; busy is low from the next cycle, and the state returns to IDLE.
REQ-026 start asserted while busy shall be ignored; num_triangles changes while busy shall have no effect.
REQ-027 The triangle index shall be 24 bits and shall not wrap within an upload; the maximum count is 2^24-1.

Reset
REQ-028 On system_rst_n low, the block shall enter IDLE immediately, mid-upload included, with: trmt=0, tri_rd=0, done=0, busy=0, tx_data=0, tri_addr=0, index=0, byte counter=0, shift register=0, checksum=0. No partial byte completion is attempted after reset.

Configuration
REQ-029 With UPLOAD_CHECKSUM_EN defined: the block keeps an 8-bit XOR of every transmitted byte (count bytes included), cleared on start; CHKSUM sends that value as one extra byte, then goes to FINISH.
REQ-030 Without UPLOAD_CHECKSUM_EN: the CHKSUM state and checksum register are absent, the last byte goes directly to FINISH, and the stream is exactly 3+18*N bytes.

Verification
REQ-031 Reset, then start with num_triangles=0 -> bytes 00 00 00, then done; tri_rd never pulses.
REQ-032 num_triangles=2, mem[0]=144'h0102…12, mem[1] all 0xAA -> 02 00 00, then 12 11 … 01, then 18×AA; tri_addr sequence 0,1; total 39 bytes.
REQ-033 tx_done delayed 100 cycles per byte, and a spurious tx_done during WAIT_RD -> byte order unchanged, trmt count equals bytes sent.
REQ-034 start re-pulsed mid-upload with num_triangles=5 -> ignored; the original count of 2 completes.
REQ-035 Reset asserted after the 10th triangle byte -> all outputs 0 next edge; a fresh start sends a clean stream from the count bytes.
REQ-036 UPLOAD_CHECKSUM_EN, num_triangles=1, mem[0]=0 -> 01 00 00, 18×00, then checksum 01.
